// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register: valid/ready handshake, flush, bubble
// insertion and an optional two-entry skid buffer that keeps in_ready registered.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic              valid_r;
  logic              ready_r;
  logic [15:0]       stall_r;
  logic              accept_s;
  logic              dequeue_s;

  // Skid mode keeps ready registered; single-register mode passes out_ready through.
  assign in_ready  = SKID ? ready_r : (!valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign dequeue_s = valid_r && out_ready;

  // Outputs come straight from the head register, which holds zeros/NOP when empty.
  assign out_valid    = valid_r;
  assign out_data     = main_data_r;
  assign out_ctrl     = main_ctrl_r;
  assign occ          = state_r;
  assign stall_cycles = stall_r;

  // Occupancy FSM: head/skid register loads, bubble clearing, registered valid/ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= CTRL_NOP;
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= CTRL_NOP;
      valid_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else if (flush) begin
      // A beat dequeued this cycle is already owned downstream; everything else dies.
      state_r     <= ST_EMPTY;
      main_data_r <= {DATA_W{1'b0}};
      main_ctrl_r <= CTRL_NOP;
      skid_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= CTRL_NOP;
      valid_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            main_data_r <= in_data;
            main_ctrl_r <= in_ctrl;
            valid_r     <= 1'b1;
            state_r     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (SKID && accept_s && !dequeue_s) begin
            skid_data_r <= in_data;
            skid_ctrl_r <= in_ctrl;
            ready_r     <= 1'b0;
            state_r     <= ST_TWO;
          end else if (accept_s) begin
            main_data_r <= in_data;
            main_ctrl_r <= in_ctrl;
          end else if (dequeue_s) begin
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= CTRL_NOP;
            valid_r     <= 1'b0;
            state_r     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (dequeue_s) begin
            main_data_r <= skid_data_r;
            main_ctrl_r <= skid_ctrl_r;
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= CTRL_NOP;
            ready_r     <= 1'b1;
            state_r     <= ST_ONE;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          main_data_r <= {DATA_W{1'b0}};
          main_ctrl_r <= CTRL_NOP;
          skid_data_r <= {DATA_W{1'b0}};
          skid_ctrl_r <= CTRL_NOP;
          valid_r     <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  // Saturating back-pressure counter; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= 16'd0;
    end else if (valid_r && !out_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two skid instances (NOP 00 / A5) and one single-register
// instance share stimulus and are checked against a queue-based reference model.
module tb_pipe_stage_skid;
  localparam int DW = 128;
  localparam int CW = 8;
  localparam int VW = 1 + 2 + 1 + CW + DW + 16;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flush;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid, z_in_ready, z_out_valid;
  logic [DW-1:0] a_out_data, b_out_data, z_out_data;
  logic [CW-1:0] a_out_ctrl, b_out_ctrl, z_out_ctrl;
  logic [1:0] a_occ, b_occ, z_occ;
  logic [15:0] a_stall, b_stall, z_stall;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(8'h00), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .flush(flush), .occ(a_occ), .stall_cycles(a_stall));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(8'hA5), .SKID(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .flush(flush), .occ(b_occ), .stall_cycles(b_stall));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(8'h00), .SKID(1'b0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
    .out_ctrl(z_out_ctrl), .flush(flush), .occ(z_occ), .stall_cycles(z_stall));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t q1[$];
  beat_t q0[$];
  int stall1 = 0;
  int stall0 = 0;
  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected observable state of a two-entry stage (queue head, size, ready rule)
  function automatic logic [VW-1:0] exp_skid(input logic [CW-1:0] nop);
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    if (q1.size() != 0) begin
      d = q1[0].d; c = q1[0].c;
    end else begin
      d = '0; c = nop;
    end
    return {q1.size() != 0, 2'(q1.size()), q1.size() != 2, c, d, 16'(stall1)};
  endfunction

  function automatic logic [VW-1:0] exp_single();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    if (q0.size() != 0) begin
      d = q0[0].d; c = q0[0].c;
    end else begin
      d = '0; c = 8'h00;
    end
    return {q0.size() != 0, 2'(q0.size()), (q0.size() == 0) || out_ready, c, d, 16'(stall0)};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r, input logic f);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
    #1;
  endtask

  // Apply the stage rules to the model with the current inputs, then advance one edge
  task automatic tick();
    beat_t b;
    logic r1, r0, v1, v0;
    b.d = in_data; b.c = in_ctrl;
    v1 = q1.size() != 0; r1 = q1.size() != 2;
    v0 = q0.size() != 0; r0 = (q0.size() == 0) || out_ready;
    if (v1 && !out_ready && stall1 < 65535) stall1++;
    if (v0 && !out_ready && stall0 < 65535) stall0++;
    if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (v1 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) q1.push_back(b);
      if (v0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #10;
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", a_out_data); end
    checks++; if (a_out_ctrl !== 8'h00) begin failures++; $display("FAIL reset_ctrl_a got=%h exp=00", a_out_ctrl); end
    checks++; if (b_out_ctrl !== 8'hA5) begin failures++; $display("FAIL reset_ctrl_b got=%h exp=a5", b_out_ctrl); end
    checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_skid got=%b exp=1", a_in_ready); end
    checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_single got=%b exp=1", z_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_streaming();
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, DW'(i), CW'(i + 1), 1'b1, 1'b0);
      if (i > 0) begin
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, a_out_valid); end
        checks++; if (a_out_data !== DW'(i - 1)) begin failures++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, a_out_data, DW'(i - 1)); end
        checks++; if (a_out_ctrl !== CW'(i)) begin failures++; $display("FAIL stream_ctrl i=%0d got=%h exp=%h", i, a_out_ctrl, CW'(i)); end
        checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL stream_occ i=%0d got=%0d exp=1", i, a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, a_in_ready); end
        checks++; if (z_out_data !== DW'(i - 1)) begin failures++; $display("FAIL stream_single_data i=%0d got=%h exp=%h", i, z_out_data, DW'(i - 1)); end
        checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL stream_single_ready i=%0d got=%b exp=1", i, z_in_ready); end
      end
      tick();
    end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== '0) begin failures++; $display("FAIL stream_end_data got=%h exp=0", a_out_data); end
    checks++; if (b_out_ctrl !== 8'hA5) begin failures++; $display("FAIL stream_end_bubble got=%h exp=a5", b_out_ctrl); end
    checks++; if (z_out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_single got=%b exp=0", z_out_valid); end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    logic [15:0] stall_before;
    acc_cnt = 0;
    stall_before = a_stall;
    for (int cyc = 0; cyc < 15; cyc++) begin
      drive(cyc < 10, rnd_data(), CW'($urandom()), !(cyc >= 3 && cyc <= 7), 1'b0);
      checks++; if ({a_out_valid, a_occ, a_in_ready, a_out_ctrl, a_out_data, a_stall} !== exp_skid(8'h00)) begin
        failures++; $display("FAIL bp_skid cyc=%0d got=%h exp=%h", cyc,
          {a_out_valid, a_occ, a_in_ready, a_out_ctrl, a_out_data, a_stall}, exp_skid(8'h00)); end
      checks++; if ({z_out_valid, z_occ, z_in_ready, z_out_ctrl, z_out_data, z_stall} !== exp_single()) begin
        failures++; $display("FAIL bp_single cyc=%0d got=%h exp=%h", cyc,
          {z_out_valid, z_occ, z_in_ready, z_out_ctrl, z_out_data, z_stall}, exp_single()); end
      if (cyc >= 4 && cyc <= 7) begin
        checks++; if ({a_occ, a_in_ready} !== 3'b100) begin failures++; $display("FAIL bp_full cyc=%0d got occ=%0d ready=%b exp occ=2 ready=0", cyc, a_occ, a_in_ready); end
      end
      if (cyc >= 3 && cyc <= 7 && in_valid && a_in_ready) acc_cnt++;
      tick();
    end
    checks++; if (acc_cnt !== 1) begin failures++; $display("FAIL bp_extra_accepts got=%0d exp=1", acc_cnt); end
    checks++; if (a_stall - stall_before !== 16'd5) begin failures++; $display("FAIL bp_stall_delta got=%0d exp=5", a_stall - stall_before); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] y;
    drive(1'b1, rnd_data(), 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, rnd_data(), 8'h22, 1'b0, 1'b0); tick();
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", a_occ); end
    drive(1'b1, rnd_data(), 8'h33, 1'b0, 1'b1); tick();
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", a_occ); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", b_out_valid); end
    checks++; if (b_out_ctrl !== 8'hA5) begin failures++; $display("FAIL flush_ctrl got=%h exp=a5", b_out_ctrl); end
    checks++; if (a_out_data !== '0) begin failures++; $display("FAIL flush_data got=%h exp=0", a_out_data); end
    checks++; if (z_occ !== 2'd0) begin failures++; $display("FAIL flush_single_occ got=%0d exp=0", z_occ); end
    checks++; if (a_stall !== 16'(stall1)) begin failures++; $display("FAIL flush_keeps_stall got=%0d exp=%0d", a_stall, stall1); end
    y = rnd_data();
    drive(1'b1, y, 8'h44, 1'b1, 1'b0); tick();
    checks++; if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b1, 8'h44, y}) begin failures++; $display("FAIL flush_next_beat got=%h exp=%h", {b_out_valid, b_out_ctrl, b_out_data}, {1'b1, 8'h44, y}); end
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_single_stall();
    logic [DW-1:0] p, q;
    p = rnd_data(); q = rnd_data();
    drive(1'b1, p, 8'h01, 1'b1, 1'b0); tick();
    drive(1'b1, q, 8'h02, 1'b0, 1'b0);
    checks++; if (z_in_ready !== 1'b0) begin failures++; $display("FAIL single_stall_ready got=%b exp=0", z_in_ready); end
    tick();
    checks++; if ({z_occ, z_out_data} !== {2'd1, p}) begin failures++; $display("FAIL single_head_held got=%h exp=%h", {z_occ, z_out_data}, {2'd1, p}); end
    drive(1'b1, q, 8'h02, 1'b1, 1'b0);
    checks++; if (z_in_ready !== 1'b1) begin failures++; $display("FAIL single_release_ready got=%b exp=1", z_in_ready); end
    tick();
    checks++; if ({z_occ, z_out_ctrl, z_out_data} !== {2'd1, 8'h02, q}) begin failures++; $display("FAIL single_swap got=%h exp=%h", {z_occ, z_out_ctrl, z_out_data}, {2'd1, 8'h02, q}); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 9) < 7, rnd_data(), CW'($urandom()), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      checks++; if ({a_out_valid, a_occ, a_in_ready, a_out_ctrl, a_out_data, a_stall} !== exp_skid(8'h00)) begin
        failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc,
          {a_out_valid, a_occ, a_in_ready, a_out_ctrl, a_out_data, a_stall}, exp_skid(8'h00)); end
      checks++; if ({b_out_valid, b_occ, b_in_ready, b_out_ctrl, b_out_data, b_stall} !== exp_skid(8'hA5)) begin
        failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc,
          {b_out_valid, b_occ, b_in_ready, b_out_ctrl, b_out_data, b_stall}, exp_skid(8'hA5)); end
      checks++; if ({z_out_valid, z_occ, z_in_ready, z_out_ctrl, z_out_data, z_stall} !== exp_single()) begin
        failures++; $display("FAIL rand_z cyc=%0d got=%h exp=%h", cyc,
          {z_out_valid, z_occ, z_in_ready, z_out_ctrl, z_out_data, z_stall}, exp_single()); end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, rnd_data(), 8'h5A, 1'b0, 1'b0); tick();
    end
    checks++; if (a_stall !== 16'hFFFF) begin failures++; $display("FAIL sat_skid got=%h exp=ffff", a_stall); end
    checks++; if (z_stall !== 16'hFFFF) begin failures++; $display("FAIL sat_single got=%h exp=ffff", z_stall); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (a_stall !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", a_stall); end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] r;
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL midrst_pre_occ got=%0d exp=2", a_occ); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL midrst_occ got=%0d exp=0", a_occ); end
    checks++; if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b0, 8'h00, {DW{1'b0}}}) begin failures++; $display("FAIL midrst_bubble got=%h exp=0", {a_out_valid, a_out_ctrl, a_out_data}); end
    checks++; if (b_out_ctrl !== 8'hA5) begin failures++; $display("FAIL midrst_ctrl_b got=%h exp=a5", b_out_ctrl); end
    checks++; if (a_stall !== 16'd0) begin failures++; $display("FAIL midrst_stall got=%h exp=0", a_stall); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", a_in_ready); end
    q1.delete(); q0.delete(); stall1 = 0; stall0 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    r = rnd_data();
    drive(1'b1, r, 8'h77, 1'b1, 1'b0); tick();
    checks++; if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 8'h77, r}) begin failures++; $display("FAIL midrst_first_accept got=%h exp=%h", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 8'h77, r}); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_single_stall();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the in-order core. It is the generalised replacement for the fixed-width inter-stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries a data bundle and a control bundle with valid/ready handshaking, stall back-pressure, synchronous flush and NOP-bubble insertion. An optional two-entry skid buffer gives registered back-pressure, so a stage's ready never has to pass combinationally through the stage.

## Interface
Parameters:
- DATA_W, default 128: width of the data bundle (pc, branch target, operands, store data, write-back address).
- CTRL_W, default 8: width of the control bundle (ALU op, mux selects, DM read/write enables).
- CTRL_NOP, default 0: control encoding driven when the stage is empty, after reset and after flush. It must encode ALU NOP with DM read and write disabled.
- SKID, default 1: 1 selects the two-entry skid buffer; 0 selects a single register with combinational ready.

Ports:
- clk  in  1  stage clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream holds a valid beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  stage presents a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  head data; all zeros when out_valid=0.
- out_ctrl  out  CTRL_W  head control; CTRL_NOP when out_valid=0.
- flush  in  1  synchronous kill of all held and incoming beats.
- occ  out  2  number of held beats: 0–2, or 0–1 when SKID=0.
- stall_cycles  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready. Dequeue: out_valid && out_ready. Beats leave in arrival order.
- SKID=1 holds a main register (head) and a skid register. States are given by occ:
  - EMPTY (0): accept → ONE, with main <= in.
  - ONE (1), accept and no dequeue → TWO, with skid <= in.
  - ONE, accept and dequeue → ONE, with main <= in.
  - ONE, dequeue only → EMPTY.
  - TWO (2): no accept is possible. Dequeue → ONE, with main <= skid.
  - in_ready = (occ != 2). It is a registered signal with no combinational path from out_ready.
- SKID=0 holds the main register only.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept loads main. A dequeue with no accept empties the stage.
- Flush:
  - On the next edge, occ=0 and out_valid=0. Both registers' contents are discarded.
  - A beat accepted in the flush cycle is dropped.
  - A dequeue in the flush cycle still counts as completed; downstream keeps that beat.
- Bubble: whenever out_valid=0, out_ctrl=CTRL_NOP and out_data=0. A held beat is never modified.
- stall_cycles increments by 1 per stall cycle and saturates at 16'hFFFF. Flush does not clear it; only rst does.

## Timing
- Reset values while rst=1: occ=0, out_valid=0, out_data=0, out_ctrl=CTRL_NOP, stall_cycles=0. in_ready is 1 for SKID=1 and 1 for SKID=0.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first accept can happen on the first rising edge after rst falls.
- Latency is 1 cycle: a beat accepted at edge N is on out_* after edge N, in cycle N+1.
- Throughput is one beat per cycle when out_ready=1 continuously, in both SKID modes.
- SKID=1: after out_ready falls, at most one further beat is accepted (into skid). in_ready drops one cycle after out_ready falls and rises one cycle after the first dequeue from TWO.
- Simultaneous events:
  - Flush has priority over accept.
  - Accept and dequeue together in ONE keep occ=1.
  - Dequeue in TWO with in_valid=1 does not accept, because in_ready=0 in that cycle.
- out_data and out_ctrl are driven only from registers; there is no input-to-output combinational path.

## Test plan
- Reset/bubble (CTRL_NOP=8'h00): assert rst mid-stream while occ=2 → out_valid=0, out_ctrl=8'h00, out_data=0 and occ=0 immediately; stall_cycles=0.
- Streaming (SKID=1): send beats D0..D9 (data=i, ctrl=i+1) back-to-back with out_ready=1 → out_valid from cycle 1, data 0..9 in order with no gaps, occ stays at 1, in_ready stays at 1.
- Skid back-pressure: stream beats with out_ready held at 0 from cycle 3 to cycle 7 → exactly one extra beat is accepted, occ=2, in_ready=0 from cycle 4. stall_cycles=5. On release, order is preserved and nothing is lost or duplicated.
- Flush (CTRL_NOP=8'hA5): flush while occ=2 with in_valid=1 → next cycle occ=0, out_valid=0, out_ctrl=8'hA5. The flush-cycle beat is never output; the next beat after flush appears with 1-cycle latency.
- SKID=0 stall: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle and the head is unchanged. Setting out_ready=1 with in_valid=1 → dequeue and accept in the same cycle, occ stays at 1.
- Saturation: hold a stall for 70000 cycles → stall_cycles reaches 16'hFFFF and stays there.
